vbuf_mch_wdma_sched: RTL and testbench
======================================

Name: vbuf_mch_wdma_sched

Overview:
- N-channel video write scheduler, successor to the single-channel frame-buffer DMA front end.
- Arbitrates line-sized DMA write bursts from CH_NUM per-channel show-ahead FIFOs onto one DMA write port.
- Generates per-channel multi-buffer addresses, with buffer rotation that skips the reader's buffer.
- Sits entirely in the DMA/AXI clock domain; pixel-side FIFOs and frame-start synchronisers are external.

Parameters:
CH_NUM, 2, number of write channels (1..8)
AXI_ADDR_WIDTH, 32, DMA address width
AXI_DATA_WIDTH, 128, DMA data width, one beat
BUF_NUM, 3, frame buffers per channel (1..4)
LINE_BEATS, 480, beats per line = burst length, must be <= 65535
H_STRIDE, 7680, byte stride between lines
V_SIZE, 1080, lines per frame
LEVEL_WIDTH, 12, FIFO level width
BASE_ADDR, 32'h1000_0000, channel 0 / buffer 0 base
BUF_OFFSET, 32'h0080_0000, byte offset between buffers
CH_OFFSET, 32'h0200_0000, byte offset between channels

Ports:
CLK  in  1  system clock
RESETN  in  1  asynchronous active-low reset
ch_fs_i  in  CH_NUM  one-cycle frame-start pulse per channel, already synchronised to CLK
ch_level_i  in  CH_NUM*LEVEL_WIDTH  FIFO fill in beats
ch_data_i  in  CH_NUM*AXI_DATA_WIDTH  FIFO show-ahead data
ch_rd_o  out  CH_NUM  FIFO read strobe
ch_rbuf_i  in  CH_NUM*2  buffer index currently held by the reader
ch_buf_o  out  CH_NUM*2  last completed buffer index
ch_irq_o  out  CH_NUM  sticky frame-done flags
irq_clr_i  in  CH_NUM  clear for ch_irq_o
dma_waddr  out  AXI_ADDR_WIDTH  burst start address
dma_wareq  out  1  burst request
dma_wsize  out  16  burst length in beats
dma_wbusy  in  1  DMA burst in progress
dma_wdata  out  AXI_DATA_WIDTH  write data
dma_wvalid  in  1  DMA consumes a beat
dma_wready  out  1  data available for granted channel
dma_wirq  out  1  one-cycle pulse on any frame completion
dma_err_o  out  1  watchdog error, sticky until reset (see Optional Feature)

Behaviour:
- Clock and reset: CLK only; RESETN asynchronous active-low.
- Reset values:
  - All outputs 0.
  - Per-channel state: active=0, line=0, wbuf=0, ch_buf_o=0, fs_pend=0.
  - Round-robin pointer = 0.
- Per-channel state:
  - ch_fs_i sets active, sets line=0, and keeps wbuf.
  - If the channel is granted at the time, the pulse is latched in fs_pend and applied in DONE.
  - A frame-start while active=1 and line!=0 aborts the frame: no irq, no buffer advance.
- Eligibility: active && level >= LINE_BEATS && !fs_pend.
- FSM states: IDLE, ARB, REQ, BUSY, DONE.
  - IDLE -> ARB when any channel is eligible.
  - ARB (1 cycle): grant the lowest eligible index at or after rr_ptr, modulo CH_NUM. Latch gnt and dma_waddr.
    - dma_waddr = BASE_ADDR + gnt*CH_OFFSET + wbuf*BUF_OFFSET + line*H_STRIDE.
    - Arithmetic is in AXI_ADDR_WIDTH; overflow wraps.
  - REQ: dma_wareq=1 until dma_wbusy is sampled high, then -> BUSY. dma_wareq drops the cycle after.
  - BUSY: wait for dma_wbusy low, then -> DONE.
  - DONE (1 cycle):
    - line+1; rr_ptr = gnt+1 mod CH_NUM.
    - If line+1 == V_SIZE: active=0, line=0, ch_buf_o[gnt]=wbuf, ch_irq_o[gnt]=1, dma_wirq pulses for 1 cycle.
    - Then wbuf advances to n = (wbuf+1) mod BUF_NUM. If BUF_NUM>=3 and n == ch_rbuf_i[gnt], use n+1 mod BUF_NUM instead.
    - Any pending fs is then applied. Return to IDLE.
- Data path (REQ or BUSY only):
  - dma_wdata = ch_data_i[gnt], combinational.
  - dma_wready = 1 while beats_left > 0.
  - ch_rd_o[gnt] = dma_wvalid && dma_wready.
  - beats_left is loaded with LINE_BEATS in ARB and decrements on each read.
  - Beats presented with beats_left == 0 are ignored: ch_rd_o stays 0.
- dma_wsize is the constant LINE_BEATS.
- Simultaneous events:
  - irq_clr_i and a new irq set in the same cycle: set wins.
  - ch_fs_i on a non-granted channel applies immediately.
- Latency: eligible -> dma_wareq is 2 cycles (IDLE->ARB->REQ).

Optional Feature:
- Macro: VBUF_WDOG_EN.
- Defined:
  - A 10-bit counter runs in REQ.
  - If dma_wbusy is not seen within 1024 cycles, dma_wareq drops, dma_err_o sets (sticky until reset), and the FSM returns to IDLE.
  - line is not advanced; rr_ptr = gnt+1.
- Not defined: REQ waits indefinitely; dma_err_o is tied 0.

Test Plan:
- Setup for all scenarios: CH_NUM=2, LINE_BEATS=4, V_SIZE=2, BUF_NUM=3, H_STRIDE=16, BASE=0, BUF_OFFSET=0x100, CH_OFFSET=0x1000.
- Single line: fs on ch0, level=4 -> dma_wareq 2 cycles later, dma_waddr=0x0, dma_wsize=4, exactly 4 ch_rd_o[0] strobes.
- Round-robin: both channels eligible at once -> grants ch0 then ch1. Addresses 0x0, 0x1000, then 0x10, 0x1010.
- Frame completion: ch0 completes 2 lines with ch_rbuf_i[0]=1 -> ch_buf_o[0]=0, dma_wirq 1 pulse, ch_irq_o[0]=1. Next frame address 0x200 (buffer 1 skipped).
- Abort: fs on ch0 after line 1 of 2 -> no irq, next address 0x0, wbuf unchanged.
- Reset mid-burst: RESETN low during BUSY -> all outputs 0 immediately; after release, dma_wareq stays 0 until a new fs.
- VBUF_WDOG_EN: hold dma_wbusy=0 -> dma_wareq drops after 1024 cycles, dma_err_o=1, line stays 0.

Source files
------------

// File: rtl/vbuf_mch_wdma_sched.sv
// Multi-channel video write scheduler: round-robin line bursts from per-channel FIFOs to one DMA
// write port, with per-channel buffer rotation. Optional REQ watchdog under `VBUF_WDOG_EN`.
module vbuf_mch_wdma_sched #(
  parameter int unsigned CH_NUM         = 2,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 128,
  parameter int unsigned BUF_NUM        = 3,
  parameter int unsigned LINE_BEATS     = 480,
  parameter int unsigned H_STRIDE       = 7680,
  parameter int unsigned V_SIZE         = 1080,
  parameter int unsigned LEVEL_WIDTH    = 12,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR  = 'h1000_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] BUF_OFFSET = 'h0080_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] CH_OFFSET  = 'h0200_0000
) (
  input  logic                             CLK,
  input  logic                             RESETN,
  input  logic [CH_NUM-1:0]                ch_fs_i,
  input  logic [CH_NUM*LEVEL_WIDTH-1:0]    ch_level_i,
  input  logic [CH_NUM*AXI_DATA_WIDTH-1:0] ch_data_i,
  output logic [CH_NUM-1:0]                ch_rd_o,
  input  logic [CH_NUM*2-1:0]              ch_rbuf_i,
  output logic [CH_NUM*2-1:0]              ch_buf_o,
  output logic [CH_NUM-1:0]                ch_irq_o,
  input  logic [CH_NUM-1:0]                irq_clr_i,
  output logic [AXI_ADDR_WIDTH-1:0]        dma_waddr,
  output logic                             dma_wareq,
  output logic [15:0]                      dma_wsize,
  input  logic                             dma_wbusy,
  output logic [AXI_DATA_WIDTH-1:0]        dma_wdata,
  input  logic                             dma_wvalid,
  output logic                             dma_wready,
  output logic                             dma_wirq,
  output logic                             dma_err_o
);

  localparam int unsigned GW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned LW = $clog2(V_SIZE + 1);
  localparam int unsigned AW = AXI_ADDR_WIDTH;

  typedef enum logic [2:0] {StIdle, StArb, StReq, StBusy, StDone} state_e;

  state_e                        state_q;
  logic [GW-1:0]                 gnt_q, rr_q, sel, rr_next;
  logic [CH_NUM-1:0]             active_q, fs_pend_q, irq_q, elig, rd;
  logic [CH_NUM-1:0][LW-1:0]     line_q;
  logic [CH_NUM-1:0][1:0]        wbuf_q, buf_q;
  logic [15:0]                   beats_q;
  logic [AW-1:0]                 waddr_q, addr_sel;
  logic                          wareq_q, wirq_q, any_elig, data_phase, granted;
  logic [1:0]                    wbuf_next;
`ifdef VBUF_WDOG_EN
  logic [9:0]                    wd_q;
  logic                          err_q;
`endif

  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      elig[c] = active_q[c] && !fs_pend_q[c] &&
                (32'(ch_level_i[c*LEVEL_WIDTH +: LEVEL_WIDTH]) >= LINE_BEATS);
    end
  end

  // Lowest eligible channel at or after rr_q, wrapping modulo CH_NUM.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    sel      = '0;
    any_elig = 1'b0;
    for (int k = 0; k < CH_NUM; k++) begin
      idx = (32'(rr_q) + 32'(k)) % CH_NUM;
      if (!any_elig && elig[idx]) begin
        any_elig = 1'b1;
        sel      = GW'(idx);
      end
    end
    addr_sel = BASE_ADDR + AW'(sel) * CH_OFFSET + AW'(wbuf_q[sel]) * BUF_OFFSET +
               AW'(line_q[sel]) * AW'(H_STRIDE);
  end

  // Next write buffer, stepping over the one the reader holds when there are enough buffers.
  always_comb begin
    int unsigned n;
    n = (32'(wbuf_q[gnt_q]) + 1) % BUF_NUM;
    if (BUF_NUM >= 3 && n == 32'(ch_rbuf_i[32'(gnt_q)*2 +: 2])) n = (n + 1) % BUF_NUM;
    wbuf_next = 2'(n);
    rr_next   = (32'(gnt_q) + 1 == CH_NUM) ? '0 : gnt_q + 1'b1;
  end

  always_comb begin
    data_phase = (state_q == StReq) || (state_q == StBusy);
    granted    = data_phase || (state_q == StDone);
    dma_wready = data_phase && (beats_q != 16'd0);
    dma_wdata  = data_phase ? ch_data_i[32'(gnt_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] : '0;
    rd         = '0;
    if (dma_wvalid && dma_wready) rd[gnt_q] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      rr_q      <= '0;
      active_q  <= '0;
      fs_pend_q <= '0;
      irq_q     <= '0;
      line_q    <= '0;
      wbuf_q    <= '0;
      buf_q     <= '0;
      beats_q   <= '0;
      waddr_q   <= '0;
      wareq_q   <= 1'b0;
      wirq_q    <= 1'b0;
`ifdef VBUF_WDOG_EN
      wd_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      wirq_q <= 1'b0;
      for (int c = 0; c < CH_NUM; c++) begin
        if (irq_clr_i[c]) irq_q[c] <= 1'b0;
        if (ch_fs_i[c]) begin
          if (granted && gnt_q == GW'(c)) begin
            fs_pend_q[c] <= 1'b1;
          end else begin
            active_q[c] <= 1'b1;
            line_q[c]   <= '0;
          end
        end
      end
      if (rd != '0) beats_q <= beats_q - 16'd1;
      unique case (state_q)
        StIdle: if (any_elig) state_q <= StArb;
        StArb: begin
          if (any_elig) begin
            gnt_q   <= sel;
            waddr_q <= addr_sel;
            beats_q <= 16'(LINE_BEATS);
            wareq_q <= 1'b1;
            state_q <= StReq;
`ifdef VBUF_WDOG_EN
            wd_q    <= '0;
`endif
          end else begin
            state_q <= StIdle;
          end
        end
        StReq: begin
          if (dma_wbusy) begin
            wareq_q <= 1'b0;
            state_q <= StBusy;
          end
`ifdef VBUF_WDOG_EN
          else if (wd_q == 10'h3ff) begin
            wareq_q <= 1'b0;
            err_q   <= 1'b1;
            rr_q    <= rr_next;
            state_q <= StIdle;
          end else begin
            wd_q <= wd_q + 10'd1;
          end
`endif
        end
        StBusy: if (!dma_wbusy) state_q <= StDone;
        StDone: begin
          rr_q    <= rr_next;
          state_q <= StIdle;
          if (32'(line_q[gnt_q]) + 1 == V_SIZE) begin
            active_q[gnt_q] <= 1'b0;
            line_q[gnt_q]   <= '0;
            buf_q[gnt_q]    <= wbuf_q[gnt_q];
            irq_q[gnt_q]    <= 1'b1;
            wirq_q          <= 1'b1;
            wbuf_q[gnt_q]   <= wbuf_next;
          end else begin
            line_q[gnt_q] <= line_q[gnt_q] + 1'b1;
          end
          // A frame start seen during the burst restarts the channel only now.
          if (fs_pend_q[gnt_q] || ch_fs_i[gnt_q]) begin
            active_q[gnt_q]  <= 1'b1;
            line_q[gnt_q]    <= '0;
            fs_pend_q[gnt_q] <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ch_rd_o   = rd;
  assign ch_buf_o  = buf_q;
  assign ch_irq_o  = irq_q;
  assign dma_waddr = waddr_q;
  assign dma_wareq = wareq_q;
  assign dma_wsize = 16'(LINE_BEATS);
  assign dma_wirq  = wirq_q;
`ifdef VBUF_WDOG_EN
  assign dma_err_o = err_q;
`else
  assign dma_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vbuf_mch_wdma_sched.sv
// Directed bench for vbuf_mch_wdma_sched: 2 channels, 4-beat lines, 2-line frames, 3 buffers.
module tb_vbuf_mch_wdma_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  fs, rd, irq, clr;
  logic [23:0] level;
  logic [63:0] data;
  logic [3:0]  rbuf, bufo;
  logic [31:0] waddr, wdata;
  logic [15:0] wsize;
  logic        wareq, wbusy, wvalid, wready, wirq, err;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  vbuf_mch_wdma_sched #(
    .CH_NUM(2), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .BUF_NUM(3), .LINE_BEATS(4),
    .H_STRIDE(16), .V_SIZE(2), .LEVEL_WIDTH(12), .BASE_ADDR(32'h0),
    .BUF_OFFSET(32'h100), .CH_OFFSET(32'h1000)
  ) dut (
    .CLK(clk), .RESETN(rstn), .ch_fs_i(fs), .ch_level_i(level), .ch_data_i(data),
    .ch_rd_o(rd), .ch_rbuf_i(rbuf), .ch_buf_o(bufo), .ch_irq_o(irq), .irq_clr_i(clr),
    .dma_waddr(waddr), .dma_wareq(wareq), .dma_wsize(wsize), .dma_wbusy(wbusy),
    .dma_wdata(wdata), .dma_wvalid(wvalid), .dma_wready(wready), .dma_wirq(wirq),
    .dma_err_o(err)
  );

  task automatic do_reset;
    rstn = 1'b0; fs = '0; clr = '0; wbusy = 1'b0; wvalid = 1'b0; level = '0; rbuf = '0;
    data = {32'hB1B1_0001, 32'hA0A0_0000};
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_fs(input logic [1:0] m);
    fs = m;
    @(negedge clk);
    fs = '0;
  endtask

  // Plays the DMA side of one burst and reports what was observed.
  task automatic dma_burst(input int ch, input bit drop, output bit seen,
                           output logic [31:0] addr, output logic [15:0] size,
                           output logic [31:0] d, output int rds, output int strays,
                           output int wirqs);
    seen = 1'b0; addr = '0; size = '0; d = '0; rds = 0; strays = 0; wirqs = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (wareq) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) return;
    addr = waddr; size = wsize;
    if (drop) level = '0;
    wbusy = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      if (rd[ch]) begin
        rds++;
        if (rds == 1) d = wdata;
      end
      if ((rd & ~(2'b01 << ch)) != 2'b00) strays++;
      @(negedge clk);
      wirqs += int'(wirq);
    end
    wvalid = 1'b0; wbusy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wirqs += int'(wirq);
    end
  endtask

  task automatic test_reset;
    do_reset();
    n_vec++; if ({wareq, wirq, wready, err, rd, irq} !== 8'h00) begin n_err++;
      $display("FAIL reset_ctrl: got %b want 00000000", {wareq, wirq, wready, err, rd, irq}); end
    n_vec++; if (waddr !== 32'h0) begin n_err++;
      $display("FAIL reset_waddr: got %h want 00000000", waddr); end
    n_vec++; if (bufo !== 4'h0) begin n_err++; $display("FAIL reset_buf: got %h want 0", bufo); end
    n_vec++; if (wdata !== 32'h0) begin n_err++;
      $display("FAIL reset_wdata: got %h want 00000000", wdata); end
  endtask

  task automatic test_single_line;
    bit s; logic [31:0] a, d; logic [15:0] sz; int r, st, w;
    do_reset();
    level = {12'd0, 12'd4};
    pulse_fs(2'b01);
    n_vec++; if (wareq !== 1'b0) begin n_err++; $display("FAIL lat_c1: got %b want 0", wareq); end
    @(negedge clk);
    n_vec++; if (wareq !== 1'b0) begin n_err++; $display("FAIL lat_c2: got %b want 0", wareq); end
    @(negedge clk);
    n_vec++; if (wareq !== 1'b1) begin n_err++; $display("FAIL lat_c3: got %b want 1", wareq); end
    dma_burst(0, 1'b0, s, a, sz, d, r, st, w);
    n_vec++; if (s !== 1'b1) begin n_err++; $display("FAIL single_req: got %b want 1", s); end
    n_vec++; if (a !== 32'h0) begin n_err++; $display("FAIL single_addr: got %h want 0", a); end
    n_vec++; if (sz !== 16'd4) begin n_err++; $display("FAIL single_size: got %0d want 4", sz); end
    n_vec++; if (r != 4 || st != 0) begin n_err++;
      $display("FAIL single_rd: got %0d/%0d want 4/0", r, st); end
    n_vec++; if (d !== 32'hA0A0_0000) begin n_err++;
      $display("FAIL single_data: got %h want a0a00000", d); end
  endtask

  task automatic test_round_robin;
    bit s; logic [31:0] a, d; logic [15:0] sz; int r, st, w;
    int          ech [4] = '{0, 1, 0, 1};
    logic [31:0] ea  [4] = '{32'h0, 32'h1000, 32'h10, 32'h1010};
    do_reset();
    level = {12'd4, 12'd4};
    pulse_fs(2'b11);
    for (int i = 0; i < 4; i++) begin
      dma_burst(ech[i], 1'b0, s, a, sz, d, r, st, w);
      n_vec++; if (s !== 1'b1 || a !== ea[i]) begin n_err++;
        $display("FAIL rr_addr%0d: got %b/%h want 1/%h", i, s, a, ea[i]); end
      n_vec++; if (r != 4 || st != 0) begin n_err++;
        $display("FAIL rr_rd%0d: got %0d/%0d want 4/0", i, r, st); end
    end
    n_vec++; if (d !== 32'hB1B1_0001) begin n_err++;
      $display("FAIL rr_data: got %h want b1b10001", d); end
  endtask

  task automatic test_frame_done;
    bit s; logic [31:0] a, d; logic [15:0] sz; int r, st, w;
    logic [31:0] ea [4] = '{32'h0, 32'h10, 32'h200, 32'h210};
    int          ew [4] = '{0, 1, 0, 1};
    do_reset();
    rbuf  = 4'b0001;
    level = {12'd0, 12'd4};
    pulse_fs(2'b01);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        n_vec++; if (irq !== 2'b01 || bufo !== 4'h0) begin n_err++;
          $display("FAIL frame1_done: got %b/%h want 01/0", irq, bufo); end
        pulse_fs(2'b01);
      end
      dma_burst(0, 1'b0, s, a, sz, d, r, st, w);
      n_vec++; if (s !== 1'b1 || a !== ea[i]) begin n_err++;
        $display("FAIL frame_addr%0d: got %b/%h want 1/%h", i, s, a, ea[i]); end
      n_vec++; if (w != ew[i]) begin n_err++;
        $display("FAIL frame_wirq%0d: got %0d want %0d", i, w, ew[i]); end
    end
    n_vec++; if (bufo !== 4'b0010) begin n_err++; $display("FAIL frame2_buf: got %h want 2", bufo); end
    clr = 2'b01;
    @(negedge clk);
    clr = 2'b00;
    n_vec++; if (irq !== 2'b00) begin n_err++; $display("FAIL irq_clr: got %b want 00", irq); end
  endtask

  task automatic test_abort;
    bit s; logic [31:0] a, d; logic [15:0] sz; int r, st, w;
    do_reset();
    level = {12'd0, 12'd4};
    pulse_fs(2'b01);
    dma_burst(0, 1'b1, s, a, sz, d, r, st, w);
    n_vec++; if (s !== 1'b1 || a !== 32'h0) begin n_err++;
      $display("FAIL abort_l0: got %b/%h want 1/0", s, a); end
    repeat (3) @(negedge clk);
    n_vec++; if (wareq !== 1'b0) begin n_err++; $display("FAIL abort_idle: got %b want 0", wareq); end
    level = {12'd0, 12'd4};
    pulse_fs(2'b01);
    dma_burst(0, 1'b0, s, a, sz, d, r, st, w);
    n_vec++; if (s !== 1'b1 || a !== 32'h0 || w != 0) begin n_err++;
      $display("FAIL abort_restart: got %b/%h/%0d want 1/0/0", s, a, w); end
    n_vec++; if (irq !== 2'b00) begin n_err++; $display("FAIL abort_irq: got %b want 00", irq); end
    dma_burst(0, 1'b0, s, a, sz, d, r, st, w);
    n_vec++; if (s !== 1'b1 || a !== 32'h10 || w != 1) begin n_err++;
      $display("FAIL abort_l1: got %b/%h/%0d want 1/10/1", s, a, w); end
  endtask

  task automatic test_reset_mid_burst;
    bit s; logic [31:0] a, d; logic [15:0] sz; int r, st, w, cnt;
    do_reset();
    level = {12'd4, 12'd0};
    pulse_fs(2'b10);
    for (int i = 0; i < 10 && !wareq; i++) @(negedge clk);
    wbusy = 1'b1; wvalid = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    n_vec++; if ({wareq, wready, wirq, rd, irq} !== 7'h00) begin n_err++;
      $display("FAIL midrst_ctrl: got %b want 0000000", {wareq, wready, wirq, rd, irq}); end
    n_vec++; if (waddr !== 32'h0 || wdata !== 32'h0) begin n_err++;
      $display("FAIL midrst_data: got %h/%h want 0/0", waddr, wdata); end
    wbusy = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cnt += int'(wareq);
    end
    n_vec++; if (cnt != 0) begin n_err++; $display("FAIL midrst_quiet: got %0d want 0", cnt); end
    pulse_fs(2'b10);
    dma_burst(1, 1'b0, s, a, sz, d, r, st, w);
    n_vec++; if (s !== 1'b1 || a !== 32'h1000 || r != 4) begin n_err++;
      $display("FAIL midrst_resume: got %b/%h/%0d want 1/1000/4", s, a, r); end
  endtask

  task automatic test_watchdog;
`ifdef VBUF_WDOG_EN
    bit s; logic [31:0] a, d; logic [15:0] sz; int r, st, w, n;
    do_reset();
    level = {12'd0, 12'd4};
    pulse_fs(2'b01);
    for (int i = 0; i < 10 && !wareq; i++) @(negedge clk);
    n = 0;
    while (wareq && n < 1100) begin
      n++;
      @(negedge clk);
    end
    n_vec++; if (n != 1024) begin n_err++; $display("FAIL wdog_len: got %0d want 1024", n); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL wdog_err: got %b want 1", err); end
    dma_burst(0, 1'b0, s, a, sz, d, r, st, w);
    n_vec++; if (s !== 1'b1 || a !== 32'h0) begin n_err++;
      $display("FAIL wdog_line: got %b/%h want 1/0", s, a); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_round_robin();
    test_frame_done();
    test_abort();
    test_reset_mid_burst();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
